div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
// Multi-cycle signed 32-bit divider serving the CPU control unit's DIV request.
// The controller raises start with A/B operands. This block iterates and returns
// quotient (for LO) and remainder (for HI) with a one-cycle done pulse.
// Divide-by-zero is flagged so the controller can take the exception path.
// It sits beside the HI/LO source muxes and replaces a combinational divider.
// PARAMETERS
// WIDTH   32   operand/result width in bits; the iteration counter is clog2(WIDTH)+1 bits
// PORTS
// clock     in   1      rising-edge clock
// reset     in   1      synchronous, active-low reset
// start     in   1      request; sampled only in IDLE
// dividend  in   WIDTH  signed dividend (RegA); sampled on the start edge
// divisor   in   WIDTH  signed divisor (RegB); sampled on the start edge
// busy      out  1      high from the start edge until done deasserts
// done      out  1      one-cycle pulse; hi/lo/div_zero are valid while it is high
// div_zero  out  1      high with done when the divisor is 0; held until the next start
// hi        out  WIDTH  remainder; sign follows the dividend
// lo        out  WIDTH  quotient; truncated toward zero
// BEHAVIOUR
// Reset (reset==0 at an edge):
// - state=IDLE; busy, done and div_zero are 0; hi and lo are 0; internal regs are cleared.
// - Reset applies in every state, including mid-division; no partial result appears.
// States: IDLE, RUN, FIX, DONE, ZERO.
// IDLE:
// - On an edge with start=1 and divisor!=0: latch |dividend| and |divisor| (WIDTH-bit magnitudes).
// - Also latch sq=sign(dividend)^sign(divisor), sr=sign(dividend), rem=0, cnt=0, and go to RUN.
// - On an edge with start=1 and divisor==0: go to ZERO.
// - start=0: stay in IDLE.
// RUN:
// - One restoring step per cycle: rem={rem[W-2:0],q[W-1]}, q<<=1.
// - Then, if rem>=mag_divisor (unsigned, W+1-bit compare): rem-=mag_divisor, q[0]=1.
// - cnt increments each step; after the WIDTH-th step go to FIX.
// FIX:
// - lo <= sq ? -q : q; hi <= sr ? -rem : rem (two's complement, WIDTH bits, wraps).
// - div_zero <= 0; go to DONE.
// DONE:
// - done=1 for exactly this cycle; go to IDLE.
// ZERO:
// - done=1 and div_zero=1 for this cycle; hi and lo keep their previous values; go to IDLE.
// Latency, with the start edge at N:
// - Normal divide: done is high in the cycle after edge N+WIDTH+1 (after edge N+33 for WIDTH=32).
// - Divide-by-zero: done is high in the cycle after edge N.
// busy: 1 in RUN, FIX, DONE and ZERO; 0 in IDLE.
// Other rules:
// - start while busy is ignored; operands are not resampled. The controller must hold until done.
// - dividend/divisor may change after the start edge without affecting the result.
// - hi and lo hold the last result until the next FIX. div_zero holds until the next start edge.
// - Most-negative case: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000 and hi=0 (wraps, no flag).
// - Magnitude of 0x80000000 is 0x80000000 unsigned; no overflow occurs inside the iteration.
// - start in the same cycle as the done pulse is ignored; it is accepted the next cycle in IDLE.
// TESTING
// 1. 7 / 2 -> after edge N+33, done=1 for one cycle, lo=3, hi=1, div_zero=0; busy was 1 for 34 cycles.
// 2. -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. 7 / -2 -> lo=0xFFFFFFFD, hi=1. -7 / -2 -> lo=3, hi=0xFFFFFFFF.
// 3. 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. 0 / 5 -> lo=0, hi=0. 5 / 7 -> lo=0, hi=5.
// 4. Start with divisor=0 after a prior result lo=3, hi=1 -> done=1 and div_zero=1 in the next cycle; lo=3, hi=1 unchanged.
// 5. 100 / 3 started; at cycle 10 pulse start with 9/3 and change operands -> still lo=33, hi=1, single done pulse.
// 6. Start 100/3; assert reset=0 at cycle 15 -> busy=0, hi=lo=0, no done pulse. Then 9/3 -> lo=3, hi=0 on schedule.

Source files
------------

// File: rtl/div_unit.sv
// Multi-cycle signed restoring divider: quotient on lo, remainder on hi,
// one-cycle done pulse, divide-by-zero flagged without touching hi/lo.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {IDLE, RUN, FIX, DONE, ZERO} state_t;

  state_t           state, stateNext;
  logic [WIDTH-1:0] quot, rem, magDiv;
  logic [WIDTH-1:0] magA, magB;
  logic [WIDTH:0]   remShift, remDiff;
  logic [CW-1:0]    cnt;
  logic             sq, sr, remGe, lastStep;

  always_comb begin
    magA     = dividend[WIDTH-1] ? -dividend : dividend;
    magB     = divisor[WIDTH-1]  ? -divisor  : divisor;
    // One extra bit so the compare stays exact when magDiv is 2^(WIDTH-1)
    remShift = {rem, quot[WIDTH-1]};
    remDiff  = remShift - {1'b0, magDiv};
    remGe    = remShift >= {1'b0, magDiv};
    lastStep = (cnt == CW'(WIDTH - 1));
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: if (start) stateNext = (divisor == '0) ? ZERO : RUN;
      RUN:  if (lastStep) stateNext = FIX;
      FIX:  stateNext = DONE;
      DONE: stateNext = IDLE;
      ZERO: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE) || (state == ZERO);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      quot     <= '0;
      rem      <= '0;
      magDiv   <= '0;
      cnt      <= '0;
      sq       <= 1'b0;
      sr       <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      state <= stateNext;
      unique case (state)
        IDLE: begin
          if (start) begin
            div_zero <= (divisor == '0);
            if (divisor != '0) begin
              quot   <= magA;
              magDiv <= magB;
              sq     <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              sr     <= dividend[WIDTH-1];
              rem    <= '0;
              cnt    <= '0;
            end
          end
        end
        RUN: begin
          rem  <= remGe ? remDiff[WIDTH-1:0] : remShift[WIDTH-1:0];
          quot <= {quot[WIDTH-2:0], remGe};
          cnt  <= cnt + 1'b1;
        end
        FIX: begin
          lo       <= sq ? -quot : quot;
          hi       <= sr ? -rem : rem;
          div_zero <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed + random bench for div_unit; expected results are queued at start
// and checked (value, latency, busy length) when done pulses.
module tb_div_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  typedef struct {
    logic [31:0] expLo;
    logic [31:0] expHi;
    logic        expDz;
    int          expCyc;
    int          expBusy;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   busyCnt = 0;

  div_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .div_zero(div_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Monitor: scoreboard pop on every done pulse
  always @(negedge clock) begin
    if (busy) busyCnt++;
    else busyCnt = 0;
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("lo", lo, e.expLo);
        check("hi", hi, e.expHi);
        check("div_zero", {31'd0, div_zero}, {31'd0, e.expDz});
        check("latency", cyc, e.expCyc);
        check("busy_len", busyCnt, e.expBusy);
      end
    end
  end

  task automatic startDiv(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eLo, input logic [31:0] eHi);
    exp_t e;
    @(negedge clock);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    e.expLo   = (b == 0) ? lo : eLo;
    e.expHi   = (b == 0) ? hi : eHi;
    e.expDz   = (b == 0);
    e.expCyc  = (b == 0) ? cyc + 1 : cyc + 34;
    e.expBusy = (b == 0) ? 1 : 34;
    sb.push_back(e);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      #1;
      if (sb.size() == 0) break;
    end
    check("done_timeout", sb.size(), 0);
  endtask

  task automatic modelDiv(input logic [31:0] a, input logic [31:0] b);
    longint sa, sbv;
    logic [63:0] q, r;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    q   = 64'(sa / sbv);
    r   = 64'(sa % sbv);
    startDiv(a, b, q[31:0], r[31:0]);
    waitIdle();
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_dz", {31'd0, div_zero}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    reset = 1'b1;

    startDiv(32'd7, 32'd2, 32'd3, 32'd1);                 waitIdle();
    startDiv(32'd12345, 32'd0, 32'd0, 32'd0);             waitIdle();
    check("dz_held", {31'd0, div_zero}, 32'd1);
    check("dz_lo_kept", lo, 32'd3);
    check("dz_hi_kept", hi, 32'd1);
    startDiv(-32'sd7, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF); waitIdle();
    startDiv(32'd7, -32'sd2, 32'hFFFFFFFD, 32'd1);        waitIdle();
    startDiv(-32'sd7, -32'sd2, 32'd3, 32'hFFFFFFFF);      waitIdle();
    startDiv(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0); waitIdle();
    startDiv(32'd0, 32'd5, 32'd0, 32'd0);                 waitIdle();
    startDiv(32'd5, 32'd7, 32'd0, 32'd5);                 waitIdle();
    startDiv(32'h7FFFFFFF, 32'h80000000, 32'd0, 32'h7FFFFFFF); waitIdle();

    // start pulsed mid-run with new operands must be ignored
    startDiv(32'd100, 32'd3, 32'd33, 32'd1);
    repeat (8) @(negedge clock);
    dividend = 32'd9; divisor = 32'd3; start = 1'b1;
    @(negedge clock);
    start = 1'b0; dividend = 32'd55; divisor = 32'd11;
    waitIdle();
    repeat (5) @(negedge clock);

    // reset mid-division: no done pulse and cleared outputs
    @(negedge clock);
    dividend = 32'd100; divisor = 32'd3; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (14) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    repeat (40) @(negedge clock);
    startDiv(32'd9, 32'd3, 32'd3, 32'd0);                 waitIdle();

    for (int i = 0; i < 8; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      if (i[0]) b = b >> $urandom_range(31, 1);
      if (b == 0) b = 32'd13;
      modelDiv(a, b);
    end

    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
